// File: rtl/torrence_params_pkg.sv
// torrence_params: shared types for the memory-side blocks.
//   memory_operation_e      - LOAD / STORE opcode carried on every memory port
//   memory_operation_size_e - access width (BYTE / HALF / WORD)
//   arb_state_e             - mem_arbiter FSM states
//   arb_policy_e            - mem_arbiter grant policy selector
package torrence_params;

    typedef enum logic {
        LOAD  = 1'b0,
        STORE = 1'b1
    } memory_operation_e;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } memory_operation_size_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

    typedef enum logic {
        ARB_ROUND_ROBIN = 1'b0,
        ARB_FIXED_PRIO  = 1'b1
    } arb_policy_e;

endpackage

// File: rtl/mem_arbiter_sat_counter.sv
// sat_counter: W-bit up-counter that sticks at all-ones.
//   clk   - clock
//   rst_n - asynchronous active-low reset, clears count
//   inc   - count one event this cycle
//   count - current value
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one backing-memory port between the I-cache (port 0)
// and the D-cache (port 1). One transaction is in flight at a time; grant
// policy is round-robin or fixed priority to port 1.
//   clk, rst_n        - clock, asynchronous active-low reset
//   req_valid/op/size/addr/wdata - per-port requests, held until fulfilled
//   req_rdata         - downstream load data, broadcast to both ports
//   req_fulfilled     - one-cycle done pulse to the owning port
//   mem_*             - downstream request / response
//   grant_cnt         - per-port completed-transaction counters (saturating)
//   contend_cnt       - IDLE cycles with both ports requesting (saturating)
module mem_arbiter
    import torrence_params::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter arb_policy_e POLICY = ARB_ROUND_ROBIN,
    parameter int unsigned CNT_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [1:0]                req_valid,
    input  logic [1:0]                req_op,
    input  logic [1:0][1:0]           req_size,
    input  logic [1:0][XLEN-1:0]      req_addr,
    input  logic [1:0][XLEN-1:0]      req_wdata,
    output logic [1:0][XLEN-1:0]      req_rdata,
    output logic [1:0]                req_fulfilled,
    output logic                      mem_valid,
    output logic                      mem_op,
    output logic [1:0]                mem_size,
    output logic [XLEN-1:0]           mem_addr,
    output logic [XLEN-1:0]           mem_wdata,
    input  logic [XLEN-1:0]           mem_rdata,
    input  logic                      mem_fulfilled,
    output logic [1:0][CNT_W-1:0]     grant_cnt,
    output logic [CNT_W-1:0]          contend_cnt
);

    arb_state_e state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_q, last_d;
    logic       winner;
    logic [1:0] grant_inc;
    logic       contend_inc;

    // Round-robin: on contention the port that did not finish last wins;
    // a lone requester always wins regardless of policy.
    always_comb begin
        if (POLICY == ARB_FIXED_PRIO) begin
            winner = req_valid[1];
        end else if (req_valid == 2'b11) begin
            winner = ~last_q;
        end else begin
            winner = req_valid[1];
        end
    end

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_d        = last_q;
        mem_valid     = 1'b0;
        mem_op        = 1'b0;
        mem_size      = '0;
        mem_addr      = '0;
        mem_wdata     = '0;
        req_fulfilled = '0;
        grant_inc     = '0;
        contend_inc   = 1'b0;
        case (state_q)
            IDLE: begin
                contend_inc = &req_valid;
                if (|req_valid) begin
                    owner_d = winner;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                mem_valid = 1'b1;
                mem_op    = req_op[owner_q];
                mem_size  = req_size[owner_q];
                mem_addr  = req_addr[owner_q];
                mem_wdata = req_wdata[owner_q];
                if (mem_fulfilled) begin
                    req_fulfilled[owner_q] = 1'b1;
                    grant_inc[owner_q]     = 1'b1;
                    last_d                 = owner_q;
                    state_d                = RELEASE;
                end
            end
            // One dead cycle lets the owner drop valid before re-arbitration.
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    assign req_rdata = {2{mem_rdata}};

    for (genvar i = 0; i < 2; i++) begin : g_grant_cnt
        sat_counter #(.W(CNT_W)) u_grant_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (grant_inc[i]),
            .count (grant_cnt[i])
        );
    end

    sat_counter #(.W(CNT_W)) u_contend_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (contend_inc),
        .count (contend_cnt)
    );

    // The owner must keep its request up for the whole transaction.
    owner_holds_valid: assert property (
        @(posedge clk) disable iff (!rst_n)
        (state_q == BUSY) |-> req_valid[owner_q]
    );

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    import torrence_params::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic sel;  // 0: round-robin DUT (CNT_W=4), 1: fixed-priority DUT (CNT_W=32)

    logic [1:0]        valid;
    logic [1:0]        op;
    logic [1:0][1:0]   size;
    logic [1:0][31:0]  addr, wdata;
    logic [31:0]       m_rdata;
    logic              m_fulfilled;

    logic [1:0] a_valid, b_valid;
    logic       a_mful, b_mful;
    assign a_valid = sel ? 2'b00 : valid;
    assign b_valid = sel ? valid : 2'b00;
    assign a_mful  = sel ? 1'b0 : m_fulfilled;
    assign b_mful  = sel ? m_fulfilled : 1'b0;

    logic [1:0][31:0] a_rdata, b_rdata;
    logic [1:0]       a_ful, b_ful;
    logic             a_mvalid, b_mvalid, a_mop, b_mop;
    logic [1:0]       a_msize, b_msize;
    logic [31:0]      a_maddr, b_maddr, a_mwdata, b_mwdata;
    logic [1:0][3:0]  a_gcnt;
    logic [3:0]       a_ccnt;
    logic [1:0][31:0] b_gcnt;
    logic [31:0]      b_ccnt;

    mem_arbiter #(.XLEN(32), .POLICY(ARB_ROUND_ROBIN), .CNT_W(4)) dut_rr (
        .clk(clk), .rst_n(rst_n), .req_valid(a_valid), .req_op(op), .req_size(size),
        .req_addr(addr), .req_wdata(wdata), .req_rdata(a_rdata), .req_fulfilled(a_ful),
        .mem_valid(a_mvalid), .mem_op(a_mop), .mem_size(a_msize), .mem_addr(a_maddr),
        .mem_wdata(a_mwdata), .mem_rdata(m_rdata), .mem_fulfilled(a_mful),
        .grant_cnt(a_gcnt), .contend_cnt(a_ccnt)
    );

    mem_arbiter #(.XLEN(32), .POLICY(ARB_FIXED_PRIO), .CNT_W(32)) dut_fp (
        .clk(clk), .rst_n(rst_n), .req_valid(b_valid), .req_op(op), .req_size(size),
        .req_addr(addr), .req_wdata(wdata), .req_rdata(b_rdata), .req_fulfilled(b_ful),
        .mem_valid(b_mvalid), .mem_op(b_mop), .mem_size(b_msize), .mem_addr(b_maddr),
        .mem_wdata(b_mwdata), .mem_rdata(m_rdata), .mem_fulfilled(b_mful),
        .grant_cnt(b_gcnt), .contend_cnt(b_ccnt)
    );

    logic [1:0][31:0] o_rdata;
    logic [1:0]       o_ful;
    logic             o_mvalid, o_mop;
    logic [1:0]       o_msize;
    logic [31:0]      o_maddr, o_mwdata, o_gcnt0, o_gcnt1, o_ccnt;

    always_comb begin
        if (sel) begin
            o_rdata = b_rdata;  o_ful = b_ful;  o_mvalid = b_mvalid;  o_mop = b_mop;
            o_msize = b_msize;  o_maddr = b_maddr;  o_mwdata = b_mwdata;
            o_gcnt0 = b_gcnt[0];  o_gcnt1 = b_gcnt[1];  o_ccnt = b_ccnt;
        end else begin
            o_rdata = a_rdata;  o_ful = a_ful;  o_mvalid = a_mvalid;  o_mop = a_mop;
            o_msize = a_msize;  o_maddr = a_maddr;  o_mwdata = a_mwdata;
            o_gcnt0 = 32'(a_gcnt[0]);  o_gcnt1 = 32'(a_gcnt[1]);  o_ccnt = 32'(a_ccnt);
        end
    end

    typedef struct {
        logic        port;
        logic        op;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    txn_t sb[$];
    int   pend[2];
    int   vecs = 0;
    int   errs = 0;
    int   w;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic o, input logic [1:0] s,
                            input logic [31:0] a, input logic [31:0] d, input int n);
        op[p] = o;  size[p] = s;  addr[p] = a;  wdata[p] = d;  pend[p] = n;
    endtask

    task automatic push(input int p);
        txn_t t;
        t.port = 1'(p);  t.op = op[p];  t.size = size[p];
        t.addr = addr[p];  t.wdata = wdata[p];
        sb.push_back(t);
    endtask

    task automatic do_reset();
        valid = '0;  m_fulfilled = 1'b0;  pend[0] = 0;  pend[1] = 0;
        sb.delete();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic chk_fields(input string tag, input txn_t e);
        chk({tag, "_mvalid"}, 32'(o_mvalid), 32'd1);
        chk({tag, "_mop"},    32'(o_mop),    32'(e.op));
        chk({tag, "_msize"},  32'(o_msize),  32'(e.size));
        chk({tag, "_maddr"},  o_maddr,       e.addr);
        chk({tag, "_mwdata"}, o_mwdata,      e.wdata);
    endtask

    // Waits for the next grant, checks it against the scoreboard head, holds it
    // for lat cycles, fulfills it, then retires the requester and checks RELEASE.
    task automatic serve(input string tag, input int lat, input logic [31:0] rd,
                         input logic [1:0] late, output int waited);
        txn_t e;
        waited = 0;
        while (o_mvalid !== 1'b1 && waited < 10) begin
            step();
            waited++;
        end
        chk({tag, "_grant"}, 32'(o_mvalid), 32'd1);
        vecs++;
        assert (sb.size() != 0) else begin
            errs++;
            $error("FAIL %s_sb: observed empty queue expected pending entry", tag);
        end
        if (sb.size() == 0) return;
        e = sb.pop_front();
        for (int c = 0; c < lat; c++) begin
            chk_fields(tag, e);
            chk({tag, "_early_ful"}, 32'(o_ful), 32'd0);
            step();
            if (c == 0) valid = valid | late;
            #1;
        end
        m_fulfilled = 1'b1;
        m_rdata     = rd;
        #1;
        chk_fields(tag, e);
        chk({tag, "_ful"}, 32'(o_ful), e.port ? 32'd2 : 32'd1);
        chk({tag, "_rdata"}, o_rdata[e.port], rd);
        step();
        m_fulfilled = 1'b0;
        m_rdata     = '0;
        pend[e.port]--;
        if (pend[e.port] == 0) valid[e.port] = 1'b0;
        #1;
        chk({tag, "_rel_mvalid"}, 32'(o_mvalid), 32'd0);
        chk({tag, "_rel_ful"}, 32'(o_ful), 32'd0);
    endtask

    initial begin
        sel = 1'b0;  valid = '0;  op = '0;  size = '0;  addr = '0;  wdata = '0;
        m_rdata = '0;  m_fulfilled = 1'b0;  pend[0] = 0;  pend[1] = 0;
        rst_n = 1'b0;
        step();
        step();
        for (int d = 0; d < 2; d++) begin
            sel = 1'(d);
            #1;
            chk("rst_mvalid", 32'(o_mvalid), 32'd0);
            chk("rst_ful",    32'(o_ful),    32'd0);
            chk("rst_gcnt0",  o_gcnt0,       32'd0);
            chk("rst_gcnt1",  o_gcnt1,       32'd0);
            chk("rst_ccnt",   o_ccnt,        32'd0);
        end
        sel = 1'b0;
        rst_n = 1'b1;
        step();

        // Single port-0 load, fulfilled 2 cycles after mem_valid.
        set_port(0, LOAD, WORD, 32'h100, 32'h0, 1);
        valid[0] = 1'b1;
        push(0);
        #1;
        chk("t1_lat0", 32'(o_mvalid), 32'd0);
        step();
        chk("t1_lat1", 32'(o_mvalid), 32'd1);
        serve("t1", 2, 32'hDEADBEEF, 2'b00, w);
        chk("t1_gcnt0", o_gcnt0, 32'd1);

        // Spurious downstream completion while idle.
        step();
        m_fulfilled = 1'b1;
        #1;
        chk("t5_spur_ful", 32'(o_ful), 32'd0);
        step();
        m_fulfilled = 1'b0;
        #1;
        chk("t5_spur_gcnt0", o_gcnt0, 32'd1);
        chk("t5_spur_mvalid", 32'(o_mvalid), 32'd0);

        // Reset asserted mid-transaction.
        set_port(0, LOAD, WORD, 32'h140, 32'h0, 1);
        valid[0] = 1'b1;
        step();
        chk("t5_busy", 32'(o_mvalid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_mvalid", 32'(o_mvalid), 32'd0);
        chk("t5_rst_gcnt0",  o_gcnt0,       32'd0);
        m_fulfilled = 1'b1;
        #1;
        chk("t5_rst_ful", 32'(o_ful), 32'd0);
        step();
        m_fulfilled = 1'b0;
        valid = '0;
        pend[0] = 0;
        rst_n = 1'b1;
        step();
        chk("t5_after_mvalid", 32'(o_mvalid), 32'd0);
        chk("t5_after_ful",    32'(o_ful),    32'd0);

        // Round-robin with both ports requesting from reset: 0,1,0,1.
        do_reset();
        set_port(0, LOAD,  WORD, 32'h1000, 32'h0,    2);
        set_port(1, STORE, WORD, 32'h2000, 32'hA5A5, 2);
        valid = 2'b11;
        push(0);  push(1);  push(0);  push(1);
        serve("t2_a", 1, 32'h11, 2'b00, w);
        serve("t2_b", 1, 32'h22, 2'b00, w);
        serve("t2_c", 1, 32'h33, 2'b00, w);
        serve("t2_d", 1, 32'h44, 2'b00, w);
        chk("t2_gcnt0", o_gcnt0, 32'd2);
        chk("t2_gcnt1", o_gcnt1, 32'd2);
        chk("t2_ccnt",  o_ccnt,  32'd3);

        // Port-1 store held while port 0 arrives mid-BUSY.
        do_reset();
        set_port(1, STORE, WORD, 32'h200, 32'h1234, 1);
        set_port(0, LOAD,  HALF, 32'h300, 32'h0,    1);
        valid = 2'b10;
        push(1);  push(0);
        serve("t4_p1", 3, 32'h0, 2'b01, w);
        serve("t4_p0", 1, 32'h55, 2'b00, w);
        chk("t4_regrant_gap", 32'(w), 32'd2);
        chk("t4_gcnt0", o_gcnt0, 32'd1);
        chk("t4_gcnt1", o_gcnt1, 32'd1);

        // Fixed priority: port 1 takes all four while port 0 waits.
        sel = 1'b1;
        do_reset();
        set_port(0, LOAD, WORD, 32'h400, 32'h0, 1);
        set_port(1, LOAD, BYTE, 32'h500, 32'h0, 4);
        valid = 2'b11;
        push(1);  push(1);  push(1);  push(1);  push(0);
        for (int i = 0; i < 4; i++) serve("t3_p1", 1, 32'(i), 2'b00, w);
        chk("t3_gcnt1", o_gcnt1, 32'd4);
        chk("t3_gcnt0", o_gcnt0, 32'd0);
        chk("t3_ccnt",  o_ccnt,  32'd4);
        serve("t3_p0", 1, 32'h77, 2'b00, w);
        chk("t3_gcnt0_late", o_gcnt0, 32'd1);

        // 4-bit grant counter saturation.
        sel = 1'b0;
        do_reset();
        set_port(0, LOAD, WORD, 32'h600, 32'h0, 16);
        valid = 2'b01;
        for (int i = 0; i < 16; i++) push(0);
        for (int i = 0; i < 16; i++) begin
            serve("t6", 1, 32'(i), 2'b00, w);
            if (i == 14) chk("t6_gcnt0_15", o_gcnt0, 32'd15);
        end
        chk("t6_hold", o_gcnt0, 32'd15);
        chk("t6_ccnt", o_ccnt,  32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
